addr_cvt_burst: RTL and testbench
=================================

Name: addr_cvt_burst

Overview:
Parametrised successor to the im2col address converter. Decodes one (Bx, By) patch request into channel/kernel-row/kernel-col and output-row/col indices, then emits a burst of up to burst_len element addresses for consecutive By positions.
- Supports configurable stride, an element-size shift, padding detection (padding beats are redirected to a zero-page address) and clipping at the end of the output plane.
- Sits between the im2col request generator and the DMA read engine.

Parameters:
ADDR_W, 32, address width of image_addr/addr0/addr.
IDX_W, 16, width of Bx, By, win_dim; also restoring-divider cycle count.
DIM_W, 8, width of image_size; image_size_pow is 2*DIM_W.
KS_W, 4, width of ksize.
BL_W, 8, width of burst_len.
ELEM_SHIFT, 0, element-to-byte shift applied to the in-image offset.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
dma_req  in  1  request valid.
dma_ready  out  1  converter idle, request accepted when dma_req&&dma_ready.
Bx  in  IDX_W  im2col row index = c*ksize^2 + ky*ksize + kx.
By  in  IDX_W  output pixel index = oy*win_dim + ox.
burst_len  in  BL_W  beats requested; 0 treated as 1.
ksize  in  KS_W  kernel size.
stride  in  2  convolution stride; 0 treated as 1.
pad  in  2  padding width.
image_addr  in  ADDR_W  base of channel 0.
image_size  in  DIM_W  input width = height.
image_size_pow  in  2*DIM_W  image_size^2 (channel pitch).
win_dim  in  IDX_W  output width = height.
addr0  in  ADDR_W  zero-page address for padding beats.
addr  out  ADDR_W  beat address.
is_pad  out  1  beat lies in the padding region.
last  out  1  final beat of the burst.
req_valid  out  1  beat valid.
req_ready  in  1  downstream accepts beat.

Behaviour:
- Reset values: addr=0, is_pad=0, last=0, req_valid=0, dma_ready=1, state=IDLE.
- Reset is asynchronous: asserting it mid-operation aborts the burst immediately, with no partial beat or flag left high.
- All configuration inputs and Bx/By/burst_len are registered on accept and ignored until the next accept.

FSM:
- IDLE: dma_ready=1. On accept, go to DIV1 and drop dma_ready on the next edge.
- DIV1: IDX_W cycles. Parallel restoring division gives oy=By/win_dim, ox=By%win_dim, c=Bx/(ksize*ksize), r=Bx%(ksize*ksize).
- DIV2: 8 cycles. ky=r/ksize, kx=r%ksize.
- CALC: 1 cycle.
  - iy = oy*stride + ky - pad and ix = ox*stride + kx - pad, as signed (DIM_W+IDX_W+2)-bit values.
  - Set the beat counter. Clip rem_beats to min(burst_len, win_dim^2 - By).
- EMIT: presents a registered beat.
  - req_valid rises exactly IDX_W+10 edges after the accept edge (26 with defaults).
  - A beat is consumed when req_valid&&req_ready.
  - Otherwise addr/is_pad/last/req_valid are held stable.
- Return: after the last beat is consumed, go to IDLE with dma_ready=1 on the same edge. A new request is accepted no earlier than the following edge.

Beat address:
- If iy<0, iy>=image_size, ix<0 or ix>=image_size: addr=addr0, is_pad=1.
- Otherwise: addr = image_addr + ((c*image_size_pow + iy*image_size + ix) << ELEM_SHIFT), truncated to ADDR_W, is_pad=0.

Beat advance (no division):
- ox+1<win_dim: ox++, ix+=stride.
- Otherwise: ox=0, ix=kx-pad, oy++, iy+=stride.

Flags and edge cases:
- last=1 on the beat where rem_beats==1.
- dma_req while busy is ignored.
- win_dim=0 or ksize=0: results are undefined, but the FSM must still complete within the fixed latency and return to IDLE without hanging.

Optional Feature:
ADDR_CVT_ERR_EN
- Defined: adds output err (1 bit, reset 0).
- In CALC, any of the following pulses err for 1 cycle, emits no beats and returns to IDLE:
  - ksize==0
  - win_dim==0
  - image_size==0
  - By>=win_dim^2
- Undefined: no err port and no checks.

Test Plan:
Common config: ksize=5, image_size=27, image_size_pow=729, pad=2, stride=1, win_dim=27, image_addr=0, addr0=1024, ELEM_SHIFT=0, req_ready=1 unless stated.
- Padding beat: Bx=0, By=0, burst_len=1 -> first req_valid 26 cycles after accept; addr=1024, is_pad=1, last=1; dma_ready=1 after handshake.
- In-image beats:
  - Bx=12, By=728, burst_len=1 -> addr=728, is_pad=0.
  - Bx=2399, By=0 -> addr=69311.
- Row wrap: Bx=12, By=25, burst_len=4 -> addrs 25, 26, 27, 28; last only on the 4th beat.
- Clip and stride:
  - Bx=12, By=727, burst_len=5 -> 2 beats (727, 728), last on 728.
  - stride=2, win_dim=14, Bx=12, By=0, burst_len=3 -> 0, 2, 4.
- Backpressure: burst_len=4 with req_ready low for 3 cycles at beat 2 -> addr/last held stable, all 4 beats delivered in order; dma_req pulses while busy ignored.
- Reset/error:
  - rst asserted mid-burst -> req_valid=0, last=0, dma_ready=1 immediately; a fresh request afterwards behaves as in the first scenario.
  - With ADDR_CVT_ERR_EN, ksize=0 -> err pulses once, no req_valid.

Source files
------------

// File: rtl/addr_cvt_burst.sv
// addr_cvt_burst
// Decodes one (Bx, By) im2col patch request into channel / kernel-row /
// kernel-col and output-row / output-col indices, then emits a burst of
// element addresses for consecutive By positions. Padding beats are
// redirected to a zero-page address. The burst is clipped at the end of
// the output plane.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   dma_req/dma_ready   request handshake; dma_ready is high only when idle
//   Bx, By, burst_len   patch request (sampled on accept)
//   ksize, stride, pad  convolution geometry (sampled on accept)
//   image_addr, image_size, image_size_pow, win_dim, addr0
//                       image layout and zero page (sampled on accept)
//   addr, is_pad, last  registered beat, qualified by req_valid
//   req_valid/req_ready beat handshake
//   err                 only when ADDR_CVT_ERR_EN is defined: one-cycle
//                       pulse on a rejected request
//
// Optional feature macro: ADDR_CVT_ERR_EN
module addr_cvt_burst #(
  parameter int ADDR_W     = 32,
  parameter int IDX_W      = 16,
  parameter int DIM_W      = 8,
  parameter int KS_W       = 4,
  parameter int BL_W       = 8,
  parameter int ELEM_SHIFT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dma_req,
  output logic                 dma_ready,
  input  logic [IDX_W-1:0]     Bx,
  input  logic [IDX_W-1:0]     By,
  input  logic [BL_W-1:0]      burst_len,
  input  logic [KS_W-1:0]      ksize,
  input  logic [1:0]           stride,
  input  logic [1:0]           pad,
  input  logic [ADDR_W-1:0]    image_addr,
  input  logic [DIM_W-1:0]     image_size,
  input  logic [2*DIM_W-1:0]   image_size_pow,
  input  logic [IDX_W-1:0]     win_dim,
  input  logic [ADDR_W-1:0]    addr0,
  output logic [ADDR_W-1:0]    addr,
  output logic                 is_pad,
  output logic                 last,
  output logic                 req_valid,
  input  logic                 req_ready
`ifdef ADDR_CVT_ERR_EN
  ,
  output logic                 err
`endif
);

  localparam int SW    = DIM_W + IDX_W + 2;   // signed image-coordinate width
  localparam int KW2   = 2 * KS_W;            // width of ksize^2 and of r
  localparam int CNT_W = $clog2(IDX_W + KW2 + 1);
  localparam int AW    = 2 * IDX_W + 1;       // width of win_dim^2 - By

  typedef enum logic [2:0] {IDLE, DIV1, DIV2, CALC, EMIT} state_t;
  state_t state_reg, state_next;

  // Request snapshot
  logic [IDX_W-1:0]   bx_reg, by_reg, win_dim_reg;
  logic [BL_W-1:0]    blen_reg;
  logic [KS_W-1:0]    ksize_reg;
  logic [1:0]         stride_reg, pad_reg;
  logic [ADDR_W-1:0]  image_addr_reg, addr0_reg;
  logic [DIM_W-1:0]   image_size_reg;
  logic [2*DIM_W-1:0] image_size_pow_reg;

  // Divider state: quotient registers start holding the dividend and shift
  // it out MSB-first while quotient bits shift in.
  logic [IDX_W-1:0]   q1a_reg, r1a_reg, q1b_reg;
  logic [KW2-1:0]     r1b_reg, q2_reg;
  logic [KS_W-1:0]    r2_reg;
  logic [CNT_W-1:0]   cnt_reg;

  // Beat walker
  logic [IDX_W-1:0]   ox_reg;
  logic [KS_W-1:0]    kx_reg;
  logic [SW-1:0]      iy_reg, ix_reg;
  logic [ADDR_W-1:0]  chan_base_reg;
  logic [BL_W-1:0]    rem_reg;

  assign dma_ready = (state_reg == IDLE);

  // ---------------- restoring division steps ----------------
  logic [KW2-1:0]   ksq;
  logic [IDX_W:0]   a_shift;
  logic [KW2:0]     b_shift;
  logic [KS_W:0]    c_shift;
  logic             a_ge, b_ge, c_ge;
  logic [IDX_W-1:0] r1a_step, q1a_step, q1b_step;
  logic [KW2-1:0]   r1b_step, q2_step;
  logic [KS_W-1:0]  r2_step;

  assign ksq      = KW2'(ksize_reg) * KW2'(ksize_reg);
  assign a_shift  = {r1a_reg, q1a_reg[IDX_W-1]};
  assign a_ge     = a_shift >= {1'b0, win_dim_reg};
  assign r1a_step = a_ge ? IDX_W'(a_shift - {1'b0, win_dim_reg}) : IDX_W'(a_shift);
  assign q1a_step = {q1a_reg[IDX_W-2:0], a_ge};
  assign b_shift  = {r1b_reg, q1b_reg[IDX_W-1]};
  assign b_ge     = b_shift >= {1'b0, ksq};
  assign r1b_step = b_ge ? KW2'(b_shift - {1'b0, ksq}) : KW2'(b_shift);
  assign q1b_step = {q1b_reg[IDX_W-2:0], b_ge};
  assign c_shift  = {r2_reg, q2_reg[KW2-1]};
  assign c_ge     = c_shift >= {1'b0, ksize_reg};
  assign r2_step  = c_ge ? KS_W'(c_shift - {1'b0, ksize_reg}) : KS_W'(c_shift);
  assign q2_step  = {q2_reg[KW2-2:0], c_ge};

  // ---------------- CALC: coordinates and clipped beat count ----------------
  logic [SW-1:0]   iy_calc, ix_calc;
  logic [AW-1:0]   avail;
  logic [BL_W-1:0] blen_eff, rem_calc;
  logic            avail_none, calc_err;

  assign iy_calc  = SW'(q1a_reg) * SW'(stride_reg) + SW'(q2_reg) - SW'(pad_reg);
  assign ix_calc  = SW'(r1a_reg) * SW'(stride_reg) + SW'(r2_reg) - SW'(pad_reg);
  assign avail    = AW'(win_dim_reg) * AW'(win_dim_reg) - AW'(by_reg);
  assign avail_none = avail[AW-1] || (avail == '0);
  assign blen_eff = (blen_reg == '0) ? BL_W'(1) : blen_reg;
  // A request past the plane end still emits one beat so the FSM always drains.
  assign rem_calc = avail_none ? BL_W'(1) :
                    (avail < AW'(blen_eff)) ? BL_W'(avail) : blen_eff;

`ifdef ADDR_CVT_ERR_EN
  assign calc_err = (ksize_reg == '0) || (win_dim_reg == '0) ||
                    (image_size_reg == '0) || avail_none;
`else
  assign calc_err = 1'b0;
`endif

  // ---------------- beat address generation ----------------
  // While a beat is showing, the next beat is built from the advanced
  // coordinates; otherwise from the current ones (first beat after CALC).
  logic [IDX_W:0]    ox_inc;
  logic              wrap;
  logic [IDX_W-1:0]  ox_adv;
  logic [SW-1:0]     iy_adv, ix_adv, beat_iy, beat_ix;
  logic              beat_pad;
  logic [ADDR_W-1:0] beat_off, beat_addr;

  assign ox_inc  = {1'b0, ox_reg} + 1'b1;
  assign wrap    = !(ox_inc < {1'b0, win_dim_reg});
  assign ox_adv  = wrap ? '0 : ox_inc[IDX_W-1:0];
  assign ix_adv  = wrap ? SW'(kx_reg) - SW'(pad_reg) : ix_reg + SW'(stride_reg);
  assign iy_adv  = wrap ? iy_reg + SW'(stride_reg) : iy_reg;
  assign beat_iy = req_valid ? iy_adv : iy_reg;
  assign beat_ix = req_valid ? ix_adv : ix_reg;
  assign beat_pad = beat_iy[SW-1] || beat_ix[SW-1] ||
                    (beat_iy >= SW'(image_size_reg)) || (beat_ix >= SW'(image_size_reg));
  assign beat_off = chan_base_reg + ADDR_W'(beat_iy) * ADDR_W'(image_size_reg) + ADDR_W'(beat_ix);
  assign beat_addr = beat_pad ? addr0_reg : image_addr_reg + (beat_off << ELEM_SHIFT);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (dma_req) state_next = DIV1;
      DIV1: if (cnt_reg == CNT_W'(IDX_W - 1)) state_next = DIV2;
      DIV2: if (cnt_reg == CNT_W'(KW2 - 1)) state_next = CALC;
      CALC: state_next = calc_err ? IDLE : EMIT;
      EMIT: if (req_valid && req_ready && rem_reg == BL_W'(1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bx_reg <= '0; by_reg <= '0; win_dim_reg <= '0; blen_reg <= '0;
      ksize_reg <= '0; stride_reg <= '0; pad_reg <= '0;
      image_addr_reg <= '0; addr0_reg <= '0; image_size_reg <= '0;
      image_size_pow_reg <= '0;
      q1a_reg <= '0; r1a_reg <= '0; q1b_reg <= '0; r1b_reg <= '0;
      q2_reg <= '0; r2_reg <= '0; cnt_reg <= '0;
      ox_reg <= '0; kx_reg <= '0; iy_reg <= '0; ix_reg <= '0;
      chan_base_reg <= '0; rem_reg <= '0;
      addr <= '0; is_pad <= 1'b0; last <= 1'b0; req_valid <= 1'b0;
`ifdef ADDR_CVT_ERR_EN
      err <= 1'b0;
`endif
    end else begin
`ifdef ADDR_CVT_ERR_EN
      err <= 1'b0;
`endif
      case (state_reg)
        IDLE: if (dma_req) begin
          bx_reg <= Bx; by_reg <= By; blen_reg <= burst_len; win_dim_reg <= win_dim;
          ksize_reg <= ksize; pad_reg <= pad;
          stride_reg <= (stride == 2'd0) ? 2'd1 : stride;
          image_addr_reg <= image_addr; addr0_reg <= addr0;
          image_size_reg <= image_size; image_size_pow_reg <= image_size_pow;
          q1a_reg <= By; r1a_reg <= '0; q1b_reg <= Bx; r1b_reg <= '0;
          cnt_reg <= '0;
        end
        DIV1: begin
          q1a_reg <= q1a_step; r1a_reg <= r1a_step;
          q1b_reg <= q1b_step; r1b_reg <= r1b_step;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(IDX_W - 1)) begin
            // r = Bx % ksize^2 becomes the dividend of the second division
            q2_reg  <= r1b_step;
            r2_reg  <= '0;
            cnt_reg <= '0;
          end
        end
        DIV2: begin
          q2_reg <= q2_step; r2_reg <= r2_step;
          cnt_reg <= cnt_reg + 1'b1;
        end
        CALC: begin
          ox_reg <= r1a_reg; kx_reg <= r2_reg;
          iy_reg <= iy_calc; ix_reg <= ix_calc;
          chan_base_reg <= ADDR_W'(q1b_reg) * ADDR_W'(image_size_pow_reg);
          rem_reg <= rem_calc;
`ifdef ADDR_CVT_ERR_EN
          err <= calc_err;
`endif
        end
        EMIT: begin
          if (!req_valid) begin
            addr <= beat_addr; is_pad <= beat_pad;
            last <= (rem_reg == BL_W'(1));
            req_valid <= 1'b1;
          end else if (req_ready) begin
            if (rem_reg == BL_W'(1)) begin
              req_valid <= 1'b0; last <= 1'b0; is_pad <= 1'b0;
            end else begin
              ox_reg <= ox_adv; iy_reg <= iy_adv; ix_reg <= ix_adv;
              rem_reg <= rem_reg - 1'b1;
              addr <= beat_addr; is_pad <= beat_pad;
              last <= (rem_reg == BL_W'(2));
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_addr_cvt_burst.sv
// Directed self-checking bench for addr_cvt_burst (default parameters).
// Defining ADDR_CVT_ERR_EN switches the final scenario to the error check.
module tb_addr_cvt_burst;

  logic        clk = 1'b0;
  logic        rst;
  logic        dma_req;
  logic        dma_ready;
  logic [15:0] Bx, By;
  logic [7:0]  burst_len;
  logic [3:0]  ksize;
  logic [1:0]  stride, pad;
  logic [31:0] image_addr;
  logic [7:0]  image_size;
  logic [15:0] image_size_pow;
  logic [15:0] win_dim;
  logic [31:0] addr0;
  logic [31:0] addr;
  logic        is_pad, last, req_valid, req_ready;
`ifdef ADDR_CVT_ERR_EN
  logic        err;
`endif

  addr_cvt_burst dut (
    .clk(clk), .rst(rst), .dma_req(dma_req), .dma_ready(dma_ready),
    .Bx(Bx), .By(By), .burst_len(burst_len), .ksize(ksize),
    .stride(stride), .pad(pad), .image_addr(image_addr),
    .image_size(image_size), .image_size_pow(image_size_pow),
    .win_dim(win_dim), .addr0(addr0), .addr(addr), .is_pad(is_pad),
    .last(last), .req_valid(req_valid), .req_ready(req_ready)
`ifdef ADDR_CVT_ERR_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int lat;
  int err_cnt;
  int valid_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_req(input logic [15:0] bx, input logic [15:0] by, input logic [7:0] bl);
    Bx = bx; By = by; burst_len = bl;
    dma_req = 1'b1;
    @(posedge clk); #1;
    dma_req = 1'b0;
    $display("req Bx=%0d By=%0d burst_len=%0d accepted", bx, by, bl);
    chk("dma_ready_drop", dma_ready, 1'b0);
  endtask

  task automatic wait_beat(output int n);
    n = 0;
    while (!req_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_valid) chk("beat_timeout", 1'b0, 1'b1);
  endtask

  task automatic expect_beat(input string tag, input logic [31:0] a, input logic p, input logic l);
    $display("beat %s: addr=%0d is_pad=%0d last=%0d", tag, addr, is_pad, last);
    chk({tag, "_valid"}, req_valid, 1'b1);
    chk({tag, "_addr"}, addr, a);
    chk({tag, "_pad"}, is_pad, p);
    chk({tag, "_last"}, last, l);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; dma_req = 1'b0; req_ready = 1'b1;
    Bx = '0; By = '0; burst_len = 8'd1;
    ksize = 4'd5; stride = 2'd1; pad = 2'd2;
    image_addr = 32'd0; image_size = 8'd27; image_size_pow = 16'd729;
    win_dim = 16'd27; addr0 = 32'd1024;

    repeat (2) @(posedge clk); #1;
    chk("rst_addr", addr, 32'd0);
    chk("rst_pad", is_pad, 1'b0);
    chk("rst_last", last, 1'b0);
    chk("rst_valid", req_valid, 1'b0);
    chk("rst_ready", dma_ready, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Padding beat and fixed latency
    start_req(16'd0, 16'd0, 8'd1);
    wait_beat(lat);
    chk("pad_latency", lat, 26);
    expect_beat("pad", 32'd1024, 1'b1, 1'b1);
    chk("pad_ready_back", dma_ready, 1'b1);
    chk("pad_valid_drop", req_valid, 1'b0);

    // In-image single beats
    start_req(16'd12, 16'd728, 8'd1);
    wait_beat(lat);
    expect_beat("img728", 32'd728, 1'b0, 1'b1);
    start_req(16'd2399, 16'd0, 8'd1);
    wait_beat(lat);
    expect_beat("chan95", 32'd69311, 1'b0, 1'b1);

    // Row wrap
    start_req(16'd12, 16'd25, 8'd4);
    wait_beat(lat);
    expect_beat("wrap0", 32'd25, 1'b0, 1'b0);
    expect_beat("wrap1", 32'd26, 1'b0, 1'b0);
    expect_beat("wrap2", 32'd27, 1'b0, 1'b0);
    expect_beat("wrap3", 32'd28, 1'b0, 1'b1);
    chk("wrap_ready_back", dma_ready, 1'b1);

    // Clip at the plane end
    start_req(16'd12, 16'd727, 8'd5);
    wait_beat(lat);
    expect_beat("clip0", 32'd727, 1'b0, 1'b0);
    expect_beat("clip1", 32'd728, 1'b0, 1'b1);
    chk("clip_done", req_valid, 1'b0);

    // Stride 2
    stride = 2'd2; win_dim = 16'd14;
    start_req(16'd12, 16'd0, 8'd3);
    stride = 2'd1; win_dim = 16'd27;   // snapshot must ignore these changes
    wait_beat(lat);
    expect_beat("str0", 32'd0, 1'b0, 1'b0);
    expect_beat("str1", 32'd2, 1'b0, 1'b0);
    expect_beat("str2", 32'd4, 1'b0, 1'b1);

    // Backpressure at beat 2 with busy dma_req pulses
    start_req(16'd12, 16'd25, 8'd4);
    dma_req = 1'b1;
    wait_beat(lat);
    expect_beat("bp0", 32'd25, 1'b0, 1'b0);
    req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", req_valid, 1'b1);
      chk("bp_hold_addr", addr, 32'd26);
      chk("bp_hold_last", last, 1'b0);
    end
    req_ready = 1'b1;
    expect_beat("bp1", 32'd26, 1'b0, 1'b0);
    expect_beat("bp2", 32'd27, 1'b0, 1'b0);
    dma_req = 1'b0;
    expect_beat("bp3", 32'd28, 1'b0, 1'b1);
    chk("bp_ready_back", dma_ready, 1'b1);
    valid_cnt = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (req_valid) valid_cnt++;
    end
    chk("bp_no_extra_beats", valid_cnt, 0);

    // Asynchronous reset while the last beat is showing
    start_req(16'd12, 16'd728, 8'd1);
    wait_beat(lat);
    chk("pre_rst_last", last, 1'b1);
    rst = 1'b1;
    #2;
    chk("arst_valid", req_valid, 1'b0);
    chk("arst_last", last, 1'b0);
    chk("arst_ready", dma_ready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    start_req(16'd0, 16'd0, 8'd1);
    wait_beat(lat);
    chk("post_rst_latency", lat, 26);
    expect_beat("post_rst", 32'd1024, 1'b1, 1'b1);

`ifdef ADDR_CVT_ERR_EN
    ksize = 4'd0;
    start_req(16'd12, 16'd0, 8'd1);
    err_cnt = 0; valid_cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (err) err_cnt++;
      if (req_valid) valid_cnt++;
    end
    chk("err_pulses", err_cnt, 1);
    chk("err_no_beats", valid_cnt, 0);
    chk("err_ready_back", dma_ready, 1'b1);
    ksize = 4'd5;
`else
    // Degenerate geometry must still drain within the fixed latency
    win_dim = 16'd0;
    start_req(16'd0, 16'd0, 8'd1);
    wait_beat(lat);
    chk("wd0_latency", lat, 26);
    @(posedge clk); #1;
    chk("wd0_ready_back", dma_ready, 1'b1);
    win_dim = 16'd27;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
